fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: reads four bytes from a byte-wide memory,
// assembles a big-endian word and offers it on a valid/ready interface.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {FETCH, DRAIN, VALID, ERROR} state_t;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        cap_en_q, cap_en_d;
  logic [1:0]  cap_idx_q, cap_idx_d;
  logic [31:0] asm_q, asm_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [1:0]  err_q, err_d;

  logic start, misaligned, out_of_range, strobe;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    err_d       = err_q;

    start        = (state_q == FETCH) && (cnt_q == 2'd0);
    misaligned   = (pc_q[1:0] != 2'b00);
    out_of_range = (pc_q > LAST_WORD);
    // The address checks gate the very first strobe of a word, so a bad pc never reaches memory.
    strobe       = (state_q == FETCH) && !(start && (misaligned || out_of_range));

    cap_en_d  = strobe;
    cap_idx_d = cnt_q;

    if (cap_en_q) begin
      case (cap_idx_q)
        2'd0:    asm_d[31:24] = mem_rdata;
        2'd1:    asm_d[23:16] = mem_rdata;
        2'd2:    asm_d[15:8]  = mem_rdata;
        default: asm_d[7:0]   = mem_rdata;
      endcase
    end

    case (state_q)
      FETCH: begin
        if (start && misaligned) begin
          state_d = ERROR;
          err_d   = 2'b01;
        end else if (start && out_of_range) begin
          state_d = ERROR;
          err_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d     = VALID;
        out_valid_d = 1'b1;
        out_instr_d = {asm_q[31:8], mem_rdata};
        out_pc_d    = pc_q;
      end
      VALID: begin
        if (out_ready) begin
          state_d     = FETCH;
          out_valid_d = 1'b0;
          pc_d        = pc_q + 32'd4;
        end
      end
      default: ;
    endcase

    // Redirect wins over every state and also over a coincident transfer.
    if (redirect) begin
      state_d     = FETCH;
      cnt_d       = 2'd0;
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      cap_en_d    = 1'b0;
      err_d       = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      cnt_q       <= 2'd0;
      pc_q        <= RESET_PC;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= 2'd0;
      asm_q       <= 32'd0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= RESET_PC;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      cap_en_q    <= cap_en_d;
      cap_idx_q   <= cap_idx_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      err_q       <= err_d;
    end
  end

  assign mem_rd_en = strobe && !rst;
  assign mem_addr  = mem_rd_en ? (pc_q + {30'd0, cnt_q}) : 32'd0;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory model, cycle-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_sequencer;

  localparam int MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] mem [MEM_BYTES];
  logic [7:0] pending = 8'h00;

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Byte memory: answers a strobe with data during the following cycle.
  always @(negedge clk) pending = mem_rd_en ? mem[mem_addr[10:0]] : 8'($urandom);
  always @(posedge clk) begin
    #1;
    mem_rdata = pending;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [10:0] i;
    i = a[10:0];
    return {mem[i], mem[11'(i + 11'd1)], mem[11'(i + 11'd2)], mem[11'(i + 11'd3)]};
  endfunction

  function automatic logic [1:0] addr_fault(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (a > 32'(MEM_BYTES - 4)) return 2'b10;
    return 2'b00;
  endfunction

  // Reference model: m_age counts cycles into the current word (0..3 strobes, 4 drain).
  int          m_age   = 0;
  logic [31:0] m_pc    = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_inerr = 1'b0;
  logic [1:0]  m_err   = 2'b00;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_opc   = 32'h0;

  initial begin
    logic exp_rd;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_rd = !rst && !m_inerr && !m_valid && (m_age < 4) &&
               !(m_age == 0 && addr_fault(m_pc) != 2'b00);
      if (!redirect) begin
        checkOutput("model_rd_en", 32'(mem_rd_en), 32'(exp_rd));
        if (exp_rd) checkOutput("model_addr", mem_addr, m_pc + 32'(m_age));
      end
      checkOutput("model_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("model_err", 32'(err), 32'(m_err));
      if (m_valid) begin
        checkOutput("model_instr", out_instr, m_instr);
        checkOutput("model_pc", out_pc, m_opc);
      end

      if (rst) begin
        m_age = 0; m_pc = 32'h0; m_valid = 0; m_inerr = 0; m_err = 0;
        m_instr = 32'h0; m_opc = 32'h0;
      end else if (redirect) begin
        m_age = 0; m_pc = redirect_pc; m_valid = 0; m_inerr = 0; m_err = 0;
      end else if (m_inerr) begin
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 0; m_age = 0; m_pc = m_pc + 32'd4;
        end
      end else if (m_age == 0 && addr_fault(m_pc) != 2'b00) begin
        m_inerr = 1; m_err = addr_fault(m_pc);
      end else if (m_age == 4) begin
        m_valid = 1; m_instr = word_at(m_pc); m_opc = m_pc;
      end else begin
        m_age++;
      end
    end
  end

  task automatic waitValid(output int c);
    bit found = 0;
    c = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        c = cyc;
      end
    end
    if (!found) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, tv;
    logic [31:0] held;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'((i * 7 + 3) & 255);
    {mem[0], mem[1], mem[2], mem[3]}             = 32'h014B_4820;
    {mem[4], mem[5], mem[6], mem[7]}             = 32'h8C22_0004;
    {mem[16], mem[17], mem[18], mem[19]}         = 32'hDEAD_BEEF;
    {mem[2044], mem[2045], mem[2046], mem[2047]} = 32'hCAFE_F00D;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_instr", out_instr, 32'h0);
    checkOutput("reset_pc", out_pc, 32'h0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_rd_en", 32'(mem_rd_en), 32'd0);

    // First word after reset release with the consumer ready.
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
    t0 = cyc;
    checkOutput("first_strobe_en", 32'(mem_rd_en), 32'd1);
    checkOutput("first_strobe_addr", mem_addr, 32'h0);
    waitValid(tv);
    checkOutput("first_latency", 32'(tv - t0), 32'd5);
    checkOutput("first_instr", out_instr, 32'h014B_4820);
    checkOutput("first_pc", out_pc, 32'h0);

    // Backpressure: hold the word at 4 for ten cycles.
    applyStimulus(0, 0, 32'h0, 0);
    waitValid(tv);
    checkOutput("stall_instr", out_instr, 32'h8C22_0004);
    checkOutput("stall_pc", out_pc, 32'h4);
    held = out_instr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_no_strobe", 32'(mem_rd_en), 32'd0);
      checkOutput("stall_hold", out_instr, held);
    end
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("resume_strobe_en", 32'(mem_rd_en), 32'd1);
    checkOutput("resume_strobe_addr", mem_addr, 32'h8);

    // Redirect during the k=2 strobe of the word at 8.
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h10, 1);
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
    checkOutput("redir_strobe_addr", mem_addr, 32'h10);
    waitValid(tv);
    checkOutput("redir_pc", out_pc, 32'h10);
    checkOutput("redir_instr", out_instr, 32'hDEAD_BEEF);

    // Redirect together with a transfer of the word at 0x14.
    applyStimulus(0, 0, 32'h0, 0);
    waitValid(tv);
    checkOutput("xfer_redir_pre_pc", out_pc, 32'h14);
    applyStimulus(0, 1, 32'h20, 1);
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
    checkOutput("xfer_redir_valid", 32'(out_valid), 32'd0);
    checkOutput("xfer_redir_addr", mem_addr, 32'h20);

    // Redirect held for three cycles; only the last target is fetched.
    applyStimulus(0, 1, 32'h24, 1);
    applyStimulus(0, 1, 32'h28, 1);
    applyStimulus(0, 1, 32'h30, 1);
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
    checkOutput("held_redir_addr", mem_addr, 32'h30);
    waitValid(tv);
    checkOutput("held_redir_pc", out_pc, 32'h30);

    // Misaligned target, then recovery by redirect.
    applyStimulus(0, 1, 32'h13, 1);
    applyStimulus(0, 0, 32'h0, 1);
    repeat (3) @(negedge clk);
    checkOutput("misalign_err", 32'(err), 32'd1);
    checkOutput("misalign_no_strobe", 32'(mem_rd_en), 32'd0);
    applyStimulus(0, 1, 32'h8, 1);
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
    checkOutput("recover_err", 32'(err), 32'd0);
    checkOutput("recover_addr", mem_addr, 32'h8);
    waitValid(tv);
    checkOutput("recover_pc", out_pc, 32'h8);

    // Misaligned and out of range at once: alignment fault reported.
    applyStimulus(0, 1, 32'h801, 1);
    applyStimulus(0, 0, 32'h0, 1);
    repeat (3) @(negedge clk);
    checkOutput("precedence_err", 32'(err), 32'd1);

    // Last legal word, then the first out-of-range address.
    applyStimulus(0, 1, 32'h7F8, 1);
    applyStimulus(0, 0, 32'h0, 1);
    waitValid(tv);
    checkOutput("edge_pc0", out_pc, 32'h7F8);
    waitValid(tv);
    checkOutput("edge_pc1", out_pc, 32'h7FC);
    checkOutput("edge_instr", out_instr, 32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    checkOutput("range_err", 32'(err), 32'd2);
    checkOutput("range_valid", 32'(out_valid), 32'd0);

    // Reset while a word is waiting; reset also beats a redirect.
    applyStimulus(0, 1, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0);
    waitValid(tv);
    checkOutput("prereset_instr", out_instr, 32'h014B_4820);
    applyStimulus(1, 1, 32'h40, 0);
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
    checkOutput("postreset_valid", 32'(out_valid), 32'd0);
    checkOutput("postreset_pc", out_pc, 32'h0);
    checkOutput("postreset_err", 32'(err), 32'd0);
    checkOutput("postreset_addr", mem_addr, 32'h0);
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
